// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default line rates and the
// clock-divider calculation used by the baud tick generator.
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } rx_state_e;

    localparam int unsigned CLK_HZ_DEF     = 100_000_000;
    localparam int unsigned BAUD_DEF       = 9600;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned den;
        den = baud * oversample;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator; restart re-phases the counter so
// that ticks line up with an externally detected event.
module uart_baud_tick #(
    parameter int unsigned DIV = 651
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        if (restart || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_feeder.sv
// 8N1 UART receiver feeding the text display: one character plus a one-cycle
// write strobe per clean frame; frames with a bad stop bit are dropped and flagged.
module uart_rx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] cout,
    output logic       we,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_LAST = SW'(OVERSAMPLE - 1);

    rx_state_e     state_q, state_d;
    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    cout_q, cout_d;
    logic          we_q, we_d;
    logic          ferr_q, ferr_d;
    logic          restart;
    logic          tick;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        cout_d  = cout_q;
        we_d    = 1'b0;
        ferr_d  = ferr_q;
        restart = 1'b0;

        case (state_q)
            StIdle: begin
                // A line held low after a bad stop bit has no 1->0 edge, so it cannot retrigger.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = StStart;
                    scnt_d  = '0;
                    restart = 1'b1;
                end
            end
            StStart: begin
                if (tick) begin
                    if (scnt_q == HALF_LAST) begin
                        scnt_d = '0;
                        if (!rx_s_q) begin
                            state_d = StData;
                            bcnt_d  = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    if (scnt_q == FULL_LAST) begin
                        scnt_d          = '0;
                        shift_d[bcnt_q] = rx_s_q;
                        if (bcnt_q == 3'd7) begin
                            state_d = StStop;
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    if (scnt_q == FULL_LAST) begin
                        scnt_d  = '0;
                        state_d = StIdle;
                        if (rx_s_q) begin
                            cout_d = shift_q;
                            we_d   = 1'b1;
                            ferr_d = 1'b0;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        scnt_d = scnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            scnt_q    <= '0;
            bcnt_q    <= '0;
            shift_q   <= '0;
            cout_q    <= '0;
            we_q      <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            scnt_q    <= scnt_d;
            bcnt_q    <= bcnt_d;
            shift_q   <= shift_d;
            cout_q    <= cout_d;
            we_q      <= we_d;
            ferr_q    <= ferr_d;
        end
    end

    assign cout      = cout_q;
    assign we        = we_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule
